writeback_sequencer: RTL
========================

Name: writeback_sequencer

Overview:
- Registered writeback stage behind the PE's destination routing logic.
- Accepts one datapath result per instruction, with its destination type, register index and output-channel mask.
- Issues a single-cycle register-file write.
- Multicasts the result to every selected output channel using per-channel valid/ready handshakes.
- Backpressures the issue stage until every targeted channel has accepted.

Parameters:
- TIA_WORD_WIDTH, 32, datapath/channel word width.
- TIA_NUM_OUTPUT_CHANNELS, 4, number of output channels; also the oci mask width.
- TIA_DT_WIDTH, 2, destination type field width.
- TIA_DI_WIDTH, 3, destination index field width; equals TIA_REGISTER_INDEX_WIDTH.
- TIA_DESTINATION_TYPE_REGISTER, 2'd1, dt encoding that selects a register write.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- issue_valid  in  1  result presented this cycle.
- issue_ready  out  1  sequencer can accept the result this cycle.
- datapath_result  in  TIA_WORD_WIDTH  ALU result.
- dt  in  TIA_DT_WIDTH  destination type.
- di  in  TIA_DI_WIDTH  destination register index.
- oci  in  TIA_NUM_OUTPUT_CHANNELS  one-hot/multi-hot output channel mask.
- register_write_enable  out  1  register file write strobe.
- register_write_index  out  TIA_DI_WIDTH  register index.
- register_write_data  out  TIA_WORD_WIDTH  register data.
- output_channel_valid  out  TIA_NUM_OUTPUT_CHANNELS  per-channel valid.
- output_channel_ready  in  TIA_NUM_OUTPUT_CHANNELS  per-channel ready.
- output_channel_data  out  [TIA_NUM_OUTPUT_CHANNELS] x TIA_WORD_WIDTH  per-channel data; 0 when that channel's valid is low.
- writeback_busy  out  1  high while in DRAIN.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE, pending=0, held_result=0.
  - All register_write_* outputs 0, all output_channel_valid 0, all output_channel_data 0.
  - Reset mid-DRAIN drops the held result and all pending sends; no partial-delivery record.
- State is IDLE or DRAIN. pending is a TIA_NUM_OUTPUT_CHANNELS-bit register.
- fire[i] = output_channel_valid[i] & output_channel_ready[i].
- remaining = pending & ~fire.
- issue_ready = (state==IDLE) | (remaining==0). It is combinational from output_channel_ready; this is intentional and gives zero-bubble back-to-back issue.
- accept = issue_valid & issue_ready.
- On accept (registered, visible the next cycle):
  - held_result <= datapath_result; pending <= oci.
  - If dt==TIA_DESTINATION_TYPE_REGISTER: register_write_enable=1, index=di, data=datapath_result for exactly one cycle. Otherwise the three register outputs are 0.
  - If oci!=0 then state <= DRAIN, else state <= IDLE.
- Register write latency: 1 cycle after accept. It is never repeated and never stalled by channel backpressure.
- DRAIN:
  - output_channel_valid = pending. output_channel_data[i] = held_result when pending[i], else 0.
  - Each cycle pending <= remaining; channels that fired drop valid the next cycle and are not resent.
  - Valid on a channel is held stable, with stable data, until that channel fires; it is never withdrawn.
  - When remaining==0 with no accept: state <= IDLE. With a same-cycle accept: reload per the accept rules.
- A new result can therefore follow the previous multicast's last handshake with no idle cycle.
- oci with all bits set and all readies high: all channels fire in the first DRAIN cycle.
- dt==register together with oci!=0 gives both the register write and the channel sends; the register write occurs in the first DRAIN cycle.
- issue_valid low: no state change other than draining.
- writeback_busy = (state==DRAIN).

Optional Feature:
TIA_WRITEBACK_STATS_EN
- Defined: adds outputs stall_cycle_count and sends_count, each 32 bits.
  - stall_cycle_count increments on every cycle with issue_valid & ~issue_ready.
  - sends_count increments by popcount(fire) each cycle.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on reset.
- Undefined: the ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Register-only write: dt=register, di=5, oci=0, result=32'hDEADBEEF, accepted at cycle N.
  - Cycle N+1: register_write_enable=1, index=5, data=DEADBEEF.
  - Cycle N+2: register_write_enable=0. issue_ready stays 1 throughout.
- Multicast with staggered readies: oci=4'b1011, result=32'h12345678, ready[0] at +1, ready[1] at +3, ready[3] at +4.
  - valid drops per channel after its fire.
  - issue_ready=0 until the cycle ready[3] is high.
  - Each channel receives 12345678 exactly once.
- Back-to-back issue: two results, oci=4'b0001, ready[0] held high.
  - Second result is accepted in the cycle the first fires.
  - Channel 0 sees consecutive words with no bubble.
- Reset mid-DRAIN: oci=4'b0110, all readies 0, reset asserted for 1 cycle.
  - All outputs 0 immediately (asynchronous); state=IDLE.
  - After release with readies high, no stale send occurs.
- Null destination: dt!=register, oci=0.
  - No register write, no channel valid; issue_ready remains 1.
- With TIA_WRITEBACK_STATS_EN: 3-channel multicast, one channel held not-ready for 4 cycles while issue_valid is high.
  - stall_cycle_count=4; sends_count=3 after completion.

Source files
------------

// File: rtl/writeback_sequencer.sv
// writeback_sequencer: registered writeback stage behind the PE destination routing.
// Accepts one result per instruction, issues a single-cycle register-file write and
// multicasts the result to every selected output channel with per-channel valid/ready,
// holding off the issue stage until every targeted channel has accepted.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-low reset
//   issue_valid / issue_ready     result handshake with the issue stage
//   datapath_result, dt, di, oci  result word, destination type, register index, channel mask
//   register_write_*              one-cycle register-file write (enable, index, data)
//   output_channel_valid/ready    per-channel handshake
//   output_channel_data           per-channel word, zero when that channel's valid is low
//   writeback_busy                high while a multicast is draining
//
// Optional feature (macro TIA_WRITEBACK_STATS_EN): adds saturating 32-bit counters
// stall_cycle_count and sends_count as extra outputs.
module writeback_sequencer #(
    parameter int unsigned TIA_WORD_WIDTH          = 32,
    parameter int unsigned TIA_NUM_OUTPUT_CHANNELS = 4,
    parameter int unsigned TIA_DT_WIDTH            = 2,
    parameter int unsigned TIA_DI_WIDTH            = 3,
    parameter logic [TIA_DT_WIDTH-1:0] TIA_DESTINATION_TYPE_REGISTER = TIA_DT_WIDTH'(1)
) (
    input  logic                                                  clock,
    input  logic                                                  reset,
    input  logic                                                  issue_valid,
    output logic                                                  issue_ready,
    input  logic [TIA_WORD_WIDTH-1:0]                             datapath_result,
    input  logic [TIA_DT_WIDTH-1:0]                               dt,
    input  logic [TIA_DI_WIDTH-1:0]                               di,
    input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                    oci,
    output logic                                                  register_write_enable,
    output logic [TIA_DI_WIDTH-1:0]                               register_write_index,
    output logic [TIA_WORD_WIDTH-1:0]                             register_write_data,
    output logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                    output_channel_valid,
    input  logic [TIA_NUM_OUTPUT_CHANNELS-1:0]                    output_channel_ready,
    output logic [TIA_NUM_OUTPUT_CHANNELS-1:0][TIA_WORD_WIDTH-1:0] output_channel_data,
    output logic                                                  writeback_busy
`ifdef TIA_WRITEBACK_STATS_EN
    ,
    output logic [31:0]                                           stall_cycle_count,
    output logic [31:0]                                           sends_count
`endif
);

    typedef enum logic {StIdle, StDrain} state_e;

    state_e                              state_q, state_d;
    logic [TIA_NUM_OUTPUT_CHANNELS-1:0]  pending_q, pending_d;
    logic [TIA_WORD_WIDTH-1:0]           held_q, held_d;
    logic                                rf_we_q, rf_we_d;
    logic [TIA_DI_WIDTH-1:0]             rf_idx_q, rf_idx_d;
    logic [TIA_WORD_WIDTH-1:0]           rf_data_q, rf_data_d;

    logic [TIA_NUM_OUTPUT_CHANNELS-1:0]  fire;
    logic [TIA_NUM_OUTPUT_CHANNELS-1:0]  remaining;
    logic                                accept;

    // Handshake decode. issue_ready depends combinationally on the channel readies so a
    // new result can be taken in the same cycle the last outstanding channel fires.
    always_comb begin
        output_channel_valid = (state_q == StDrain) ? pending_q : '0;
        fire                 = output_channel_valid & output_channel_ready;
        remaining            = pending_q & ~fire;
        issue_ready          = (state_q == StIdle) || (remaining == '0);
        accept               = issue_valid && issue_ready;
    end

    always_comb begin
        state_d   = state_q;
        pending_d = remaining;
        held_d    = held_q;
        rf_we_d   = 1'b0;
        rf_idx_d  = '0;
        rf_data_d = '0;

        if (state_q == StDrain && remaining == '0) begin
            state_d = StIdle;
        end

        if (accept) begin
            held_d    = datapath_result;
            pending_d = oci;
            state_d   = (oci != '0) ? StDrain : StIdle;
            if (dt == TIA_DESTINATION_TYPE_REGISTER) begin
                rf_we_d   = 1'b1;
                rf_idx_d  = di;
                rf_data_d = datapath_result;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            pending_q <= '0;
            held_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_idx_q  <= '0;
            rf_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            held_q    <= held_d;
            rf_we_q   <= rf_we_d;
            rf_idx_q  <= rf_idx_d;
            rf_data_q <= rf_data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(TIA_NUM_OUTPUT_CHANNELS); i++) begin
            output_channel_data[i] = output_channel_valid[i] ? held_q : '0;
        end
    end

    assign register_write_enable = rf_we_q;
    assign register_write_index  = rf_idx_q;
    assign register_write_data   = rf_data_q;
    assign writeback_busy        = (state_q == StDrain);

`ifdef TIA_WRITEBACK_STATS_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] sends_q, sends_d;
    logic [32:0] sends_sum;

    always_comb begin
        stall_d = stall_q;
        if (issue_valid && !issue_ready && stall_q != '1) begin
            stall_d = stall_q + 32'd1;
        end
        sends_sum = {1'b0, sends_q};
        for (int i = 0; i < int'(TIA_NUM_OUTPUT_CHANNELS); i++) begin
            sends_sum = sends_sum + 33'(fire[i]);
        end
        // Saturate instead of wrapping.
        sends_d = sends_sum[32] ? '1 : sends_sum[31:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            sends_q <= '0;
        end else begin
            stall_q <= stall_d;
            sends_q <= sends_d;
        end
    end

    assign stall_cycle_count = stall_q;
    assign sends_count       = sends_q;
`endif

endmodule
